// File: rtl/shrimp_fetch_pkg.sv
// Shared widths and state encoding for the shrimp fetch sequencer.
package shrimp_fetch_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;
  localparam int PC_STEP = 2;

  typedef enum logic [2:0] {
    REQ    = 3'd0,
    WAIT   = 3'd1,
    HOLD   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4,
    FAULT  = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/shrimp_fetch_sequencer_if.sv
// Counter, instruction-memory and decode signals of the fetch sequencer.
// master = sequencer side, slave = surrounding counter/memory/decode side.
interface shrimp_fetch_sequencer_if;
  import shrimp_fetch_pkg::*;

  logic [ADDR_W-1:0]  pc_in;
  logic               pc_reset;
  logic               pc_jump;
  logic [ADDR_W-1:0]  pc_jump_addr;
  logic               mem_req_valid;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_req_ready;
  logic               mem_resp_valid;
  logic [INSTR_W-1:0] mem_resp_data;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_addr;
  logic               instr_ready;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_addr;
  logic               halt;
  logic               halted;
  logic               fault;

  modport master (
    input  pc_in, mem_req_ready, mem_resp_valid, mem_resp_data,
           instr_ready, redirect_valid, redirect_addr, halt,
    output pc_reset, pc_jump, pc_jump_addr, mem_req_valid, mem_req_addr,
           instr_valid, instr_data, instr_addr, halted, fault
  );

  modport slave (
    output pc_in, mem_req_ready, mem_resp_valid, mem_resp_data,
           instr_ready, redirect_valid, redirect_addr, halt,
    input  pc_reset, pc_jump, pc_jump_addr, mem_req_valid, mem_req_addr,
           instr_valid, instr_data, instr_addr, halted, fault
  );

endinterface

// File: rtl/shrimp_fetch_sequencer.sv
// Fetch sequencer: steers the instruction counter and issues one fetch at a time.
// Define SHRIMP_FETCH_ALIGN_CHECK_EN to trap misaligned redirects in a sticky FAULT state.
module shrimp_fetch_sequencer
  import shrimp_fetch_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  shrimp_fetch_sequencer_if.master  bus
);

  localparam logic [2:0] ST_REQ    = REQ;
  localparam logic [2:0] ST_WAIT   = WAIT;
  localparam logic [2:0] ST_HOLD   = HOLD;
  localparam logic [2:0] ST_DRAIN  = DRAIN;
  localparam logic [2:0] ST_HALTED = HALTED;
`ifdef SHRIMP_FETCH_ALIGN_CHECK_EN
  localparam logic [2:0] ST_FAULT  = FAULT;
`endif

  logic [2:0]         state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  redir_target;
  logic               in_fault;

  assign redir_target = {bus.redirect_addr[ADDR_W-1:1], 1'b0};

`ifdef SHRIMP_FETCH_ALIGN_CHECK_EN
  assign in_fault = (state_q == ST_FAULT);
`else
  assign in_fault = 1'b0;
`endif

  always_comb begin
    // NOTE: every output and next-state gets a default first so no path leaves it unassigned (no latches).
    state_d           = state_q;
    instr_d           = instr_q;
    bus.pc_reset      = reset;
    bus.pc_jump       = 1'b1;
    bus.pc_jump_addr  = bus.pc_in;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = bus.pc_in;
    bus.instr_valid   = 1'b0;
    bus.instr_data    = instr_q;
    bus.instr_addr    = bus.pc_in;
    bus.halted        = 1'b0;
    bus.fault         = 1'b0;

    case (state_q)
      ST_REQ: begin
        bus.mem_req_valid = !bus.halt;
        if (bus.redirect_valid)
          state_d = (!bus.halt && bus.mem_req_ready) ? ST_DRAIN : ST_REQ;
        else if (bus.halt)
          state_d = ST_HALTED;
        else if (bus.mem_req_ready)
          state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_resp_valid) begin
          if (bus.redirect_valid) begin
            state_d = ST_REQ;
          end else begin
            instr_d = bus.mem_resp_data;
            state_d = ST_HOLD;
          end
        end else if (bus.redirect_valid) begin
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        // A redirect kills the held word, so it is never offered as accepted.
        bus.instr_valid = !bus.redirect_valid;
        if (bus.redirect_valid) begin
          state_d = ST_REQ;
        end else if (bus.instr_ready) begin
          bus.pc_jump = 1'b0;
          state_d     = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (bus.mem_resp_valid) state_d = ST_REQ;
      end
      ST_HALTED: begin
        bus.halted = 1'b1;
        if (!bus.halt && !bus.redirect_valid) state_d = ST_REQ;
      end
`ifdef SHRIMP_FETCH_ALIGN_CHECK_EN
      ST_FAULT: bus.fault = 1'b1;
`endif
      default: state_d = ST_REQ;
    endcase

    if (bus.redirect_valid && !in_fault) begin
      bus.pc_jump = 1'b1;
`ifdef SHRIMP_FETCH_ALIGN_CHECK_EN
      if (bus.redirect_addr[0]) begin
        bus.pc_jump_addr = bus.pc_in;
        bus.instr_valid  = 1'b0;
        state_d          = ST_FAULT;
      end else begin
        bus.pc_jump_addr = redir_target;
      end
`else
      bus.pc_jump_addr = redir_target;
`endif
    end

    if (reset) begin
      bus.pc_jump       = 1'b0;
      bus.mem_req_valid = 1'b0;
      bus.instr_valid   = 1'b0;
      bus.halted        = 1'b0;
      bus.fault         = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_REQ;
      // NOTE: instr_q is only observed in HOLD, but clearing it keeps the decode bus deterministic after reset.
      instr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_shrimp_fetch_sequencer.sv
// Scoreboard bench for shrimp_fetch_sequencer: directed scenarios, then randomized traffic
// against a program-order model (next delivered word = previous address + 2, or a redirect target).
module tb_shrimp_fetch_sequencer;
  import shrimp_fetch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shrimp_fetch_sequencer_if bus ();

  shrimp_fetch_sequencer dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int delivered   = 0;

  logic [15:0] exp_q[$];
  int          mem_lat  = 0;
  bit          mem_rand = 1'b0;
  bit          pending  = 1'b0;
  logic [15:0] pend_addr;
  int          lat_left;

  // Instruction counter model: reset to 0, load on jump, otherwise step by 2.
  always @(posedge clk) begin
    if (bus.pc_reset)     bus.pc_in <= 16'h0000;
    else if (bus.pc_jump) bus.pc_in <= bus.pc_jump_addr;
    else                  bus.pc_in <= bus.pc_in + 16'd2;
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1111;
    if (a == 16'h0002) return 16'h2222;
    return {a[7:0], a[15:8]} ^ 16'hC35A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic redirect(input logic [15:0] a);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = a;
    exp_q.delete();
    exp_q.push_back({a[15:1], 1'b0});
  endtask

  // Instruction memory: accepts one request, answers after 0..N extra cycles with a 1-cycle pulse.
  initial begin
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_resp_valid = 1'b0;
      if (reset) begin
        pending = 1'b0;
      end else if (pending) begin
        if (lat_left == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = mem_word(pend_addr);
          pending = 1'b0;
        end else begin
          lat_left--;
        end
      end
      @(negedge clk);
      if (!reset && bus.mem_req_valid && bus.mem_req_ready) begin
        check("one_outstanding", {31'd0, pending}, 32'd0);
        pending   = 1'b1;
        pend_addr = bus.mem_req_addr;
        lat_left  = mem_rand ? int'($urandom_range(3, 0)) : mem_lat;
      end
    end
  end

  // Decode-side monitor: every accepted instruction is popped against the model.
  initial begin
    logic [15:0] a;
    forever begin
      @(negedge clk);
      if (!reset && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_instr: got addr %h, none expected at %0t", bus.instr_addr, $time);
        end else begin
          a = exp_q.pop_front();
          check("instr_addr", {16'd0, bus.instr_addr}, {16'd0, a});
          check("instr_data", {16'd0, bus.instr_data}, {16'd0, mem_word(a)});
          exp_q.push_back(a + 16'd2);
          delivered++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0]  iv;
    bit          stable;
    logic [31:0] r;

    reset              = 1'b1;
    bus.mem_req_ready  = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    bus.halt           = 1'b0;
    exp_q.push_back(16'h0000);

    smp();
    check("rst_pc_reset",  {31'd0, bus.pc_reset}, 32'd1);
    check("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    check("rst_instr_vld", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_halted",    {31'd0, bus.halted}, 32'd0);
    check("rst_fault",     {31'd0, bus.fault}, 32'd0);
    check("rst_pc_jump",   {31'd0, bus.pc_jump}, 32'd0);

    // Zero-latency fetches: instr_valid every third cycle.
    cyc(); reset = 1'b0;
    smp();
    check("req0_valid", {31'd0, bus.mem_req_valid}, 32'd1);
    check("req0_addr",  {16'd0, bus.mem_req_addr}, 32'h0000);
    iv[0] = bus.instr_valid;
    for (int k = 1; k < 6; k++) begin
      cyc(); smp();
      iv[k] = bus.instr_valid;
      if (k == 3) check("req1_addr", {16'd0, bus.mem_req_addr}, 32'h0002);
    end
    check("valid_cadence", {26'd0, iv}, 32'b100100);

    // Decode stalls for 5 cycles in HOLD.
    stable = 1'b1;
    for (int k = 6; k < 13; k++) begin
      cyc();
      if (k == 6) bus.instr_ready = 1'b0;
      smp();
      if (k >= 8)
        stable &= (bus.pc_in == 16'h0004) && bus.instr_valid &&
                  (bus.instr_data == mem_word(16'h0004)) && !bus.mem_req_valid;
    end
    check("hold_stable", {31'd0, stable}, 32'd1);
    cyc(); bus.instr_ready = 1'b1; smp();

    // Redirect in WAIT, stale response two cycles later is drained.
    cyc(); mem_lat = 2; smp();
    check("req_addr6", {16'd0, bus.mem_req_addr}, 32'h0006);
    cyc(); redirect(16'h0040); smp();
    cyc(); bus.redirect_valid = 1'b0; smp();
    check("drain_pc",  {16'd0, bus.pc_in}, 32'h0040);
    check("drain_req", {31'd0, bus.mem_req_valid}, 32'd0);
    cyc(); smp();
    check("drain_no_instr", {31'd0, bus.instr_valid}, 32'd0);
    cyc(); mem_lat = 0; smp();
    check("redir_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
    check("redir_req_addr",  {16'd0, bus.mem_req_addr}, 32'h0040);

    // Redirect in HOLD while decode is ready: word at 0x40 dropped.
    cyc(); smp();
    cyc(); redirect(16'h0080); smp();
    cyc(); bus.redirect_valid = 1'b0; smp();
    check("hold_redir_pc",  {16'd0, bus.pc_in}, 32'h0080);
    check("hold_redir_req", {16'd0, bus.mem_req_addr}, 32'h0080);
    cyc(); smp();
    cyc(); smp();

    // Halt in REQ for 4 cycles.
    cyc(); bus.halt = 1'b1; smp();
    check("halt_no_req", {31'd0, bus.mem_req_valid}, 32'd0);
    stable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(); smp();
      stable &= bus.halted && !bus.mem_req_valid && (bus.pc_in == 16'h0082);
    end
    check("halt_hold", {31'd0, stable}, 32'd1);
    cyc(); bus.halt = 1'b0; smp();
    cyc(); smp();
    check("resume_valid", {31'd0, bus.mem_req_valid}, 32'd1);
    check("resume_addr",  {16'd0, bus.mem_req_addr}, 32'h0082);
    cyc(); smp();
    cyc(); smp();

    // Misaligned redirect while REQ is not accepted.
    cyc();
    bus.mem_req_ready  = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 16'h0041;
    exp_q.delete();
`ifndef SHRIMP_FETCH_ALIGN_CHECK_EN
    exp_q.push_back(16'h0040);
`endif
    smp();
    cyc(); bus.redirect_valid = 1'b0; bus.mem_req_ready = 1'b1; smp();
`ifdef SHRIMP_FETCH_ALIGN_CHECK_EN
    check("misalign_pc",    {16'd0, bus.pc_in}, 32'h0084);
    check("misalign_fault", {31'd0, bus.fault}, 32'd1);
    stable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 16'h0100;
      end else begin
        bus.redirect_valid = 1'b0;
      end
      smp();
      stable &= bus.fault && !bus.mem_req_valid && !bus.instr_valid;
    end
    check("fault_sticky",    {31'd0, stable}, 32'd1);
    check("fault_pc_frozen", {16'd0, bus.pc_in}, 32'h0084);
`else
    check("misalign_pc",    {16'd0, bus.pc_in}, 32'h0040);
    check("misalign_fault", {31'd0, bus.fault}, 32'd0);
`endif

    // Reset clears everything, then randomized traffic.
    cyc();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.halt = 1'b0;
    exp_q.delete();
    exp_q.push_back(16'h0000);
    cyc();
    cyc(); reset = 1'b0; smp();
    check("fault_cleared", {31'd0, bus.fault}, 32'd0);
    check("post_rst_pc",   {16'd0, bus.pc_in}, 32'h0000);

    mem_rand = 1'b1;
    delivered = 0;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      bus.mem_req_ready = ($urandom_range(3, 0) != 0);
      bus.instr_ready   = ($urandom_range(9, 0) < 7);
      if ($urandom_range(15, 0) == 0) bus.halt = ~bus.halt;
      if (i == 0) begin
        redirect(16'hFFFE);
      end else if ($urandom_range(19, 0) == 0) begin
        r = $urandom;
        redirect({r[15:1], 1'b0});
      end else begin
        bus.redirect_valid = 1'b0;
      end
    end
    cyc();
    bus.redirect_valid = 1'b0;
    bus.halt = 1'b0;
    bus.instr_ready = 1'b1;
    bus.mem_req_ready = 1'b1;
    repeat (20) cyc();
    smp();
    check("random_progress", {31'd0, delivered > 100}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
